// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage sitting directly upstream of the instruction memory.
// Owns the program counter, presents it to the memory, and buffers the
// returned {pc, instruction} pairs in a small FIFO toward decode using a
// valid/ready handshake. A redirect restarts fetch at a new PC and flushes
// every buffered entry.
//
// Ports:
//   sysclk          system clock, all state updates on the rising edge
//   reset           synchronous, active-high reset
//   imem_addr       PC presented to the instruction memory (copy of pc_q)
//   imem_data       instruction returned for imem_addr in the same cycle
//   redirect_valid  single-cycle request to restart fetch at redirect_pc
//   redirect_pc     new fetch PC, bits [1:0] forced to zero
//   id_valid        head of the fetch buffer is valid
//   id_ready        decode accepts the head entry this cycle
//   id_pc           PC of the head entry
//   id_instr        instruction of the head entry
//   buf_count       number of occupied buffer entries
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                       sysclk,
  input  logic                       reset,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_instr,
  output logic [$clog2(DEPTH):0]     buf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_q;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   entry_pc    [DEPTH];
  logic [31:0]   entry_instr [DEPTH];

  logic          pop;
  logic          push;
  logic [CW-1:0] count_next;

  // Handshake qualifiers: a redirect blocks the push; a full buffer may still
  // push when the head leaves in the same cycle.
  always_comb begin
    pop  = id_valid && id_ready;
    push = !redirect_valid && ((count < CW'(DEPTH)) || pop);
  end

  // Occupancy update; a redirect discards everything, including the head.
  always_comb begin
    count_next = count;
    if (redirect_valid) begin
      count_next = {CW{1'b0}};
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  // Program counter, pointers and occupancy.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      count  <= {CW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
    end else if (redirect_valid) begin
      pc_q   <= {redirect_pc[31:2], 2'b00};
      count  <= {CW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
    end else begin
      count <= count_next;
      if (push) begin
        // 32-bit modulo arithmetic: the PC simply wraps past the top.
        pc_q   <= pc_q + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Buffer storage; push already excludes redirect cycles.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_pc[i]    <= 32'h0000_0000;
        entry_instr[i] <= 32'h0000_0000;
      end
    end else if (push) begin
      entry_pc[wr_ptr]    <= pc_q;
      entry_instr[wr_ptr] <= imem_data;
    end
  end

  // imem_addr depends only on pc_q, so there is no path from id_ready.
  assign imem_addr = pc_q;
  assign id_valid  = (count != {CW{1'b0}});
  assign id_pc     = entry_pc[rd_ptr];
  assign id_instr  = entry_instr[rd_ptr];
  assign buf_count = count;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed bench for if_fetch_stage. Two instances share the stimulus: one
// with RESET_PC = 0 and one with RESET_PC = 32'hFFFF_FFF8 for the PC wrap case.
// The instruction memory model returns addr ^ 32'hA5A5_0000.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;

  logic [31:0] imem_addr_a,  imem_data_a,  id_pc_a,  id_instr_a;
  logic        id_valid_a;
  logic [1:0]  buf_count_a;

  logic [31:0] imem_addr_b,  imem_data_b,  id_pc_b,  id_instr_b;
  logic        id_valid_b;
  logic [1:0]  buf_count_b;

  int vectors = 0;
  int errors  = 0;

  always #5 sysclk = ~sysclk;

  assign imem_data_a = imem_addr_a ^ 32'hA5A5_0000;
  assign imem_data_b = imem_addr_b ^ 32'hA5A5_0000;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .sysclk         (sysclk),
    .reset          (reset),
    .imem_addr      (imem_addr_a),
    .imem_data      (imem_data_a),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid_a),
    .id_ready       (id_ready),
    .id_pc          (id_pc_a),
    .id_instr       (id_instr_a),
    .buf_count      (buf_count_a)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut_hi (
    .sysclk         (sysclk),
    .reset          (reset),
    .imem_addr      (imem_addr_b),
    .imem_data      (imem_data_b),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid_b),
    .id_ready       (id_ready),
    .id_pc          (id_pc_b),
    .id_instr       (id_instr_b),
    .buf_count      (buf_count_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check_head_a(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(id_valid_a), 32'd1);
    check({tag, "_pc"},    id_pc_a,         pc);
    check({tag, "_instr"}, id_instr_a,      pc ^ 32'hA5A5_0000);
  endtask

  task automatic check_head_b(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(id_valid_b), 32'd1);
    check({tag, "_pc"},    id_pc_b,         pc);
    check({tag, "_instr"}, id_instr_b,      pc ^ 32'hA5A5_0000);
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    id_ready       = 1'b0;

    // ---- Reset state --------------------------------------------------------
    tick(); tick();
    check("rst_valid",  32'(id_valid_a),  32'd0);
    check("rst_pc",     id_pc_a,          32'h0000_0000);
    check("rst_instr",  id_instr_a,       32'h0000_0000);
    check("rst_count",  32'(buf_count_a), 32'd0);
    check("rst_addr",   imem_addr_a,      32'h0000_0000);
    check("rst_addr_hi", imem_addr_b,     32'hFFFF_FFF8);

    // ---- Streaming with id_ready=1 -----------------------------------------
    reset    = 1'b0;
    id_ready = 1'b1;
    tick(); check_head_a("s0", 32'h0000_0000);
    tick(); check_head_a("s1", 32'h0000_0004);
    tick(); check_head_a("s2", 32'h0000_0008);
    tick(); check_head_a("s3", 32'h0000_000C);
    check("s3_count", 32'(buf_count_a), 32'd1);

    // ---- Fill with id_ready=0, then drain with push/pop --------------------
    reset    = 1'b1;
    id_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("f1_count", 32'(buf_count_a), 32'd1);
    tick();
    check("f2_count", 32'(buf_count_a), 32'd2);
    check("f2_addr",  imem_addr_a,      32'h0000_0008);
    tick();
    check("f3_count", 32'(buf_count_a), 32'd2);
    check("f3_addr",  imem_addr_a,      32'h0000_0008);
    check_head_a("f3", 32'h0000_0000);
    id_ready = 1'b1;
    tick();
    check_head_a("d0", 32'h0000_0004);
    check("d0_count", 32'(buf_count_a), 32'd2);
    tick();
    check_head_a("d1", 32'h0000_0008);
    check("d1_count", 32'(buf_count_a), 32'd2);

    // ---- Redirect while full with id_ready=1 -------------------------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    check("r_count", 32'(buf_count_a), 32'd0);
    check("r_valid", 32'(id_valid_a),  32'd0);
    check("r_addr",  imem_addr_a,      32'h0000_0100);
    tick();
    check_head_a("r1", 32'h0000_0100);
    tick();
    check_head_a("r2", 32'h0000_0104);

    // ---- Back-to-back redirects, last wins ---------------------------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_pc    = 32'h0000_0306;
    tick();
    redirect_valid = 1'b0;
    check("bb_addr",  imem_addr_a,      32'h0000_0304);
    check("bb_count", 32'(buf_count_a), 32'd0);
    tick();
    check_head_a("bb1", 32'h0000_0304);

    // ---- Reset mid-stream with concurrent redirect -------------------------
    tick();
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0500;
    tick();
    check("mr_valid", 32'(id_valid_a),  32'd0);
    check("mr_pc",    id_pc_a,          32'h0000_0000);
    check("mr_instr", id_instr_a,       32'h0000_0000);
    check("mr_count", 32'(buf_count_a), 32'd0);
    check("mr_addr",  imem_addr_a,      32'h0000_0000);
    check("mr_addr_hi", imem_addr_b,    32'hFFFF_FFF8);

    // ---- PC wrap on the high RESET_PC instance -----------------------------
    redirect_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick(); check_head_b("w0", 32'hFFFF_FFF8);
    tick(); check_head_b("w1", 32'hFFFF_FFFC);
    tick(); check_head_b("w2", 32'h0000_0000);
    tick(); check_head_b("w3", 32'h0000_0004);
    check("w3_addr", imem_addr_b, 32'h0000_0008);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory's PC address. It captures the returned instruction code and buffers {pc, instruction} pairs in a small FIFO toward the decode stage, using a valid/ready handshake. Decode or execute can redirect the PC (branch/jump), which flushes any buffered instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
DEPTH, 2, number of fetch-buffer entries; legal values 2, 4 or 8.

Ports:
sysclk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
imem_addr  out  32  PC presented to the instruction memory; combinational copy of pc_q.
imem_data  in  32  instruction code from the instruction memory; combinational, valid in the same cycle as imem_addr.
redirect_valid  in  1  single-cycle request to restart fetch at redirect_pc.
redirect_pc  in  32  new fetch PC; bits [1:0] ignored and treated as 0.
id_valid  out  1  head of the fetch buffer is valid.
id_ready  in  1  decode accepts the head entry this cycle.
id_pc  out  32  PC of the head entry.
id_instr  out  32  instruction of the head entry.
buf_count  out  $clog2(DEPTH)+1  number of occupied buffer entries (debug/LED use).

Behaviour:
- Reset, evaluated on a sysclk edge with reset=1:
  - pc_q = RESET_PC; count = 0; read and write pointers = 0; all entries = 0.
  - Therefore id_valid = 0, id_pc = 0, id_instr = 0, buf_count = 0, imem_addr = RESET_PC.
  - Reset overrides redirect, push and pop.
- Definitions:
  - pop = id_valid && id_ready.
  - push = !redirect_valid && (count < DEPTH || pop).
- Push: write {pc_q, imem_data} at the write pointer; advance the write pointer; pc_q <= pc_q + 4.
- PC arithmetic: 32-bit modulo, so 32'hFFFF_FFFC + 4 = 32'h0000_0000. No carry-out and no fault.
- Pop: advance the read pointer. Both pointers wrap modulo DEPTH.
- Push and pop in the same cycle: count is unchanged. This is legal when the buffer is full.
- Full with no pop: no push; pc_q holds; imem_addr stays stable.
- Redirect (priority over push and pop):
  - count <= 0; both pointers <= 0.
  - pc_q <= {redirect_pc[31:2], 2'b00}.
  - No entry is written that cycle.
  - The head entry is discarded even if id_ready=1. Decode must treat a redirect cycle's handshake as not accepted.
  - Back-to-back redirects are allowed; the last one wins.
- Output view:
  - id_valid = (count != 0).
  - id_pc and id_instr are the entry at the read pointer, stable while id_valid=1 and id_ready=0.
  - Entries not at the head are not observable.
- Latency:
  - The first edge after reset deasserts pushes the entry for RESET_PC, so id_valid=1 one cycle after reset drops.
  - After a redirect edge, the first new entry is visible one further cycle later (redirect-to-valid = 2 edges).
- Throughput: one instruction per cycle sustained while id_ready=1.
- No combinational path from id_ready to imem_addr. imem_addr depends only on pc_q.

Test Plan:
- Reset then id_ready=1, memory returns instr = addr ^ 32'hA5A5_0000.
  - id_valid rises one cycle after reset drops.
  - id_pc sequence 0,4,8,12, with matching id_instr, one per cycle.
- id_ready=0 from reset.
  - buf_count reaches DEPTH (2) holding PCs 0,4.
  - imem_addr holds at 8.
  - Raising id_ready delivers 0,4,8 in order with no gap or duplicate.
- Buffer full (PCs 0,4), id_ready=1, simultaneous push/pop.
  - buf_count stays 2.
  - Outputs advance 0 -> 4 -> 8 with no bubble.
- Redirect to 32'h0000_0103 while buffer holds 2 entries and id_ready=1.
  - Next cycle: buf_count=0, id_valid=0, imem_addr=32'h100.
  - Following cycle: id_pc=32'h100.
- Reset asserted mid-stream with a redirect in the same cycle.
  - All outputs reach their reset values.
  - imem_addr=RESET_PC; the redirect is ignored.
- Reset with RESET_PC=32'hFFFF_FFF8, id_ready=1.
  - id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
